// File: rtl/cal_pkg.sv
// Shared types, BCD month constants and BCD helper functions for the calendar sequencer.
`default_nettype none

package cal_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, EVAL = 1'b1} state_e;
  typedef enum logic [0:0] {OP_TICK = 1'b0, OP_LOAD = 1'b1} op_e;

  localparam logic [7:0] M_JAN = 8'h01;
  localparam logic [7:0] M_FEB = 8'h02;
  localparam logic [7:0] M_MAR = 8'h03;
  localparam logic [7:0] M_APR = 8'h04;
  localparam logic [7:0] M_MAY = 8'h05;
  localparam logic [7:0] M_JUN = 8'h06;
  localparam logic [7:0] M_JUL = 8'h07;
  localparam logic [7:0] M_AUG = 8'h08;
  localparam logic [7:0] M_SEP = 8'h09;
  localparam logic [7:0] M_OCT = 8'h10;
  localparam logic [7:0] M_NOV = 8'h11;
  localparam logic [7:0] M_DEC = 8'h12;

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    logic [7:0] d;
    case (month)
      M_JAN, M_MAR, M_MAY, M_JUL, M_AUG, M_OCT, M_DEC: d = 8'h31;
      M_APR, M_JUN, M_SEP, M_NOV:                      d = 8'h30;
      M_FEB:                                           d = leap ? 8'h29 : 8'h28;
      default:                                         d = 8'h00;
    endcase
    return d;
  endfunction

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  function automatic logic bcd_valid8(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_leap_check.sv
// Leap qualification of a two-digit BCD year: divisible by 4 without binary conversion.
`default_nettype none

module bcd_leap_check (
  input  logic [7:0] bcd_i,
  output logic       leap_o
);

  logic [3:0] ones;
  logic       tens_odd;

  assign ones     = bcd_i[3:0];
  assign tens_odd = bcd_i[4];

  // 10*t + o is a multiple of 4 iff o%4==0 for even t, or o%4==2 for odd t.
  assign leap_o = tens_odd ? ((ones == 4'd2) || (ones == 4'd6))
                           : ((ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8));

endmodule

`default_nettype wire

// File: rtl/calendar_advance_ctrl.sv
// BCD date sequencer: advances day/month/year on day_tick and arbitrates validated host loads.
`default_nettype none

module calendar_advance_ctrl
  import cal_pkg::*;
#(
  parameter logic [7:0] RESET_DAY   = 8'h01,
  parameter logic [7:0] RESET_MONTH = 8'h01,
  parameter logic [7:0] RESET_YEAR  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       load_valid,
  input  logic [7:0] load_day,
  input  logic [7:0] load_month,
  input  logic [7:0] load_year,
  output logic       load_ready,
  output logic       load_err,
  output logic       busy,
  output logic       done,
  output logic       tick_missed,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       leap_year
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] ld_day_q, ld_day_d;
  logic [7:0] ld_month_q, ld_month_d;
  logic [7:0] ld_year_q, ld_year_d;
  logic [7:0] day_q, day_d;
  logic [7:0] month_q, month_d;
  logic [7:0] year_q, year_d;
  logic       done_q, done_d;
  logic       load_err_q, load_err_d;
  logic       tick_missed_q, tick_missed_d;

  logic       leap_cur;
  logic       leap_ld;
  logic [7:0] mlen_cur;
  logic [7:0] mlen_ld;
  logic [7:0] tick_day, tick_month, tick_year;
  logic       ld_ok;

  bcd_leap_check u_leap_cur (
    .bcd_i  (year_q),
    .leap_o (leap_cur)
  );

  bcd_leap_check u_leap_ld (
    .bcd_i  (ld_year_q),
    .leap_o (leap_ld)
  );

  assign mlen_cur = days_in_month(month_q, leap_cur);
  assign mlen_ld  = days_in_month(ld_month_q, leap_ld);

  // Valid BCD digits compare correctly as plain hex values.
  always_comb begin
    tick_day   = bcd_inc8(day_q);
    tick_month = month_q;
    tick_year  = year_q;
    if (day_q >= mlen_cur) begin
      tick_day = 8'h01;
      if (month_q < M_DEC) begin
        tick_month = bcd_inc8(month_q);
      end else begin
        tick_month = M_JAN;
        tick_year  = bcd_inc8(year_q);
      end
    end
  end

  assign ld_ok = bcd_valid8(ld_day_q) && bcd_valid8(ld_month_q) && bcd_valid8(ld_year_q)
              && (ld_month_q >= M_JAN) && (ld_month_q <= M_DEC)
              && (ld_day_q >= 8'h01) && (ld_day_q <= mlen_ld);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ld_day_d      = ld_day_q;
    ld_month_d    = ld_month_q;
    ld_year_d     = ld_year_q;
    day_d         = day_q;
    month_d       = month_q;
    year_d        = year_q;
    done_d        = 1'b0;
    load_err_d    = 1'b0;
    tick_missed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          ld_day_d      = load_day;
          ld_month_d    = load_month;
          ld_year_d     = load_year;
          op_d          = OP_LOAD;
          state_d       = EVAL;
          tick_missed_d = day_tick;
        end else if (day_tick) begin
          op_d    = OP_TICK;
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d       = IDLE;
        tick_missed_d = day_tick;
        if (op_q == OP_LOAD) begin
          if (ld_ok) begin
            day_d   = ld_day_q;
            month_d = ld_month_q;
            year_d  = ld_year_q;
            done_d  = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
        end else begin
          day_d   = tick_day;
          month_d = tick_month;
          year_d  = tick_year;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= OP_TICK;
      ld_day_q      <= 8'h00;
      ld_month_q    <= 8'h00;
      ld_year_q     <= 8'h00;
      day_q         <= RESET_DAY;
      month_q       <= RESET_MONTH;
      year_q        <= RESET_YEAR;
      done_q        <= 1'b0;
      load_err_q    <= 1'b0;
      tick_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      ld_day_q      <= ld_day_d;
      ld_month_q    <= ld_month_d;
      ld_year_q     <= ld_year_d;
      day_q         <= day_d;
      month_q       <= month_d;
      year_q        <= year_d;
      done_q        <= done_d;
      load_err_q    <= load_err_d;
      tick_missed_q <= tick_missed_d;
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q == EVAL);
  assign done        = done_q;
  assign load_err    = load_err_q;
  assign tick_missed = tick_missed_q;
  assign day         = day_q;
  assign month       = month_q;
  assign year        = year_q;
  assign leap_year   = leap_cur;

endmodule

`default_nettype wire

// File: tb/tb_calendar_advance_ctrl.sv
// Self-checking bench: integer calendar model compared every cycle plus literal date pins.
`default_nettype none

module tb_calendar_advance_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_day = 8'h00;
  logic [7:0] load_month = 8'h00;
  logic [7:0] load_year = 8'h00;
  logic       load_ready, load_err, busy, done, tick_missed, leap_year;
  logic [7:0] day, month, year;

  int checks = 0;
  int failures = 0;

  calendar_advance_ctrl #(
    .RESET_DAY   (8'h01),
    .RESET_MONTH (8'h01),
    .RESET_YEAR  (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .day_tick    (day_tick),
    .load_valid  (load_valid),
    .load_day    (load_day),
    .load_month  (load_month),
    .load_year   (load_year),
    .load_ready  (load_ready),
    .load_err    (load_err),
    .busy        (busy),
    .done        (done),
    .tick_missed (tick_missed),
    .day         (day),
    .month       (month),
    .year        (year),
    .leap_year   (leap_year)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (binary calendar) ----------------
  int e_day = 1, e_mon = 1, e_yr = 0;
  bit e_done = 0, e_err = 0, e_miss = 0;
  bit m_inflight = 0, m_isload = 0, m_ld_ok = 0;
  int m_ld_d = 0, m_ld_m = 0, m_ld_y = 0;

  function automatic int mdays(input int m, input int y);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4) == 0) return 29;
    return tbl[m-1];
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      e_day = 1; e_mon = 1; e_yr = 0;
      e_done = 0; e_err = 0; e_miss = 0; m_inflight = 0;
    end else begin
      e_done = 0; e_err = 0; e_miss = 0;
      if (m_inflight) begin
        if (m_isload) begin
          if (m_ld_ok) begin
            e_day = m_ld_d; e_mon = m_ld_m; e_yr = m_ld_y; e_done = 1;
          end else begin
            e_err = 1;
          end
        end else begin
          if (e_day < mdays(e_mon, e_yr)) e_day++;
          else begin
            e_day = 1;
            if (e_mon < 12) e_mon++;
            else begin e_mon = 1; e_yr = (e_yr + 1) % 100; end
          end
          e_done = 1;
        end
        e_miss = day_tick;
        m_inflight = 0;
      end else if (load_valid) begin
        m_ld_ok = (load_day[7:4] <= 9) && (load_day[3:0] <= 9) &&
                  (load_month[7:4] <= 9) && (load_month[3:0] <= 9) &&
                  (load_year[7:4] <= 9) && (load_year[3:0] <= 9);
        m_ld_d = 10 * int'(load_day[7:4]) + int'(load_day[3:0]);
        m_ld_m = 10 * int'(load_month[7:4]) + int'(load_month[3:0]);
        m_ld_y = 10 * int'(load_year[7:4]) + int'(load_year[3:0]);
        if (m_ld_ok) m_ld_ok = (m_ld_m >= 1) && (m_ld_m <= 12);
        if (m_ld_ok) m_ld_ok = (m_ld_d >= 1) && (m_ld_d <= mdays(m_ld_m, m_ld_y));
        m_isload = 1; m_inflight = 1;
        e_miss = day_tick;
      end else if (day_tick) begin
        m_isload = 0; m_inflight = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_day", day, to_bcd(e_day));
    chk("m_month", month, to_bcd(e_mon));
    chk("m_year", year, to_bcd(e_yr));
    chk("m_leap", {7'd0, leap_year}, {7'd0, (e_yr % 4) == 0});
    chk("m_busy", {7'd0, busy}, {7'd0, m_inflight});
    chk("m_ready", {7'd0, load_ready}, {7'd0, !m_inflight});
    chk("m_done", {7'd0, done}, {7'd0, e_done});
    chk("m_err", {7'd0, load_err}, {7'd0, e_err});
    chk("m_miss", {7'd0, tick_missed}, {7'd0, e_miss});
  end

  // ---------------- directed stimulus ----------------
  // Each op returns at the negedge just after its commit edge.
  task automatic do_tick();
    @(negedge clk) day_tick = 1'b1;
    @(negedge clk) day_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
    @(negedge clk);
    load_valid = 1'b1; load_day = d; load_month = m; load_year = y;
    @(negedge clk) load_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_date(input string name, input logic [7:0] d, input logic [7:0] m,
                          input logic [7:0] y);
    chk({name, "_day"}, day, d);
    chk({name, "_month"}, month, m);
    chk({name, "_year"}, year, y);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_date("reset", 8'h01, 8'h01, 8'h00);
    chk("reset_leap", {7'd0, leap_year}, 8'd1);
    chk("reset_ready", {7'd0, load_ready}, 8'd1);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(8'h28, 8'h02, 8'h24);
    chk("load1_done", {7'd0, done}, 8'd1);
    @(negedge clk) day_tick = 1'b1;
    @(negedge clk) day_tick = 1'b0;
    chk("tick_busy", {7'd0, busy}, 8'd1);
    chk("tick_ready", {7'd0, load_ready}, 8'd0);
    @(negedge clk);
    chk("tick_done", {7'd0, done}, 8'd1);
    chk_date("feb29", 8'h29, 8'h02, 8'h24);
    @(negedge clk);
    chk("tick_done_clr", {7'd0, done}, 8'd0);
    do_tick();
    chk_date("mar1_24", 8'h01, 8'h03, 8'h24);

    do_load(8'h28, 8'h02, 8'h23);
    do_tick();
    chk_date("mar1_23", 8'h01, 8'h03, 8'h23);

    do_load(8'h31, 8'h12, 8'h99);
    chk("y99_leap", {7'd0, leap_year}, 8'd0);
    do_tick();
    chk_date("wrap", 8'h01, 8'h01, 8'h00);
    chk("y00_leap", {7'd0, leap_year}, 8'd1);

    do_load(8'h29, 8'h02, 8'h12);
    chk("ld12_done", {7'd0, done}, 8'd1);
    chk_date("ld12", 8'h29, 8'h02, 8'h12);
    do_load(8'h29, 8'h02, 8'h14);
    chk("ld14_err", {7'd0, load_err}, 8'd1);
    chk("ld14_done", {7'd0, done}, 8'd0);
    do_load(8'h31, 8'h04, 8'h24);
    chk("ld_apr31_err", {7'd0, load_err}, 8'd1);
    do_load(8'h00, 8'h05, 8'h24);
    chk("ld_day0_err", {7'd0, load_err}, 8'd1);
    do_load(8'h1A, 8'h01, 8'h24);
    chk("ld_nib_err", {7'd0, load_err}, 8'd1);
    chk_date("unchanged", 8'h29, 8'h02, 8'h12);

    do_load(8'h09, 8'h09, 8'h19);
    @(negedge clk) day_tick = 1'b1;
    @(negedge clk);
    @(negedge clk) day_tick = 1'b0;
    chk("b2b_miss", {7'd0, tick_missed}, 8'd1);
    chk_date("b2b", 8'h10, 8'h09, 8'h19);
    repeat (2) @(negedge clk);
    chk_date("b2b_once", 8'h10, 8'h09, 8'h19);

    @(negedge clk);
    load_valid = 1'b1; day_tick = 1'b1;
    load_day = 8'h30; load_month = 8'h09; load_year = 8'h19;
    @(negedge clk) begin load_valid = 1'b0; day_tick = 1'b0; end
    chk("both_miss", {7'd0, tick_missed}, 8'd1);
    @(negedge clk);
    chk_date("both", 8'h30, 8'h09, 8'h19);
    do_tick();
    chk_date("oct1", 8'h01, 8'h10, 8'h19);

    @(negedge clk) day_tick = 1'b1;
    @(negedge clk) begin day_tick = 1'b0; rst_n = 1'b0; end
    #1 chk_date("abort", 8'h01, 8'h01, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    do_tick();
    chk_date("post_rst", 8'h02, 8'h01, 8'h00);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
